// File: rtl/avalon_frame_reader_pkg.sv
// Shared definitions for the frame-buffer reader and its write-side counterpart.
// Pixel word layout is 0x00RRGGBB, one pixel per Avalon word, linear raster order.
package avalon_frame_reader_pkg;

  localparam int unsigned STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_ISSUE = 2'd1;
  localparam logic [STATE_W-1:0] ST_DRAIN = 2'd2;
  localparam logic [STATE_W-1:0] ST_DONE  = 2'd3;

  localparam int unsigned PIX_W = 24;

  // Field order fixes R at [23:16], G at [15:8], B at [7:0].
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic int unsigned frame_pixels(input int unsigned h, input int unsigned v);
    return h * v;
  endfunction

endpackage

// File: rtl/frame_reader_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; head entry is visible on rdata.
module frame_reader_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  // A pop on an empty FIFO is dropped; a push on a full FIFO is legal only alongside a pop.
  always_comb begin
    do_pop  = pop & (cnt_q != '0);
    do_push = push & ((cnt_q != CNT_W'(DEPTH)) | do_pop);
    wr_d    = wr_q + PTR_W'(do_push);
    rd_d    = rd_q + PTR_W'(do_pop);
    cnt_d   = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

  assign rdata = mem_q[rd_q];
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/avalon_frame_reader.sv
// Avalon-MM read master that streams one frame from the LPDDR2 frame buffer as pixels.
// Reads are credit-limited by FIFO space so returned data can always be stored.
module avalon_frame_reader
  import avalon_frame_reader_pkg::*;
#(
  parameter int unsigned ADDR_W     = 27,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned H_ACTIVE   = 1920,
  parameter int unsigned V_ACTIVE   = 1080,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              local_init_done,
  input  logic              frame_start,
  input  logic              avl_waitrequest_n,
  output logic [ADDR_W-1:0] avl_address,
  output logic              avl_read,
  output logic              avl_burstbegin,
  input  logic [DATA_W-1:0] avl_readdata,
  input  logic              avl_readdatavalid,
  output logic [23:0]       pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              busy,
  output logic              frame_done,
  output logic              err_unexpected
);

  localparam int unsigned FRAME_PIXELS = frame_pixels(H_ACTIVE, V_ACTIVE);
  localparam int unsigned CNT_W        = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned X_W          = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned Y_W          = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ISSUE = ADDR_W'(FRAME_PIXELS - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d, issue_q, issue_d;
  logic               read_q, read_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [CNT_W-1:0]   out_q, out_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;

  logic [PIX_W-1:0]   fifo_rdata;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               accept, push, pop, has_credit;
  logic [CNT_W:0]     credit_sum;
  rgb_t               head_px;
  logic               unused_readdata;

  assign unused_readdata = ^avl_readdata[DATA_W-1:PIX_W];

  frame_reader_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (iCLK),
    .rst   (iRST),
    .push  (push),
    .wdata (avl_readdata[PIX_W-1:0]),
    .pop   (pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Handshakes and read credit; credit looks at occupancy after this cycle's updates.
  always_comb begin
    accept     = read_q & avl_waitrequest_n;
    push       = avl_readdatavalid & (out_q != '0);
    pop        = ~fifo_empty & pix_ready;
    out_d      = out_q + CNT_W'(accept) - CNT_W'(push);
    credit_sum = (CNT_W+1)'(out_d) + (CNT_W+1)'(fifo_count)
               + (CNT_W+1)'(push) - (CNT_W+1)'(pop);
    has_credit = credit_sum < (CNT_W+1)'(FIFO_DEPTH);
    err_d      = err_q | (avl_readdatavalid & (out_q == '0));
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    issue_d = issue_q;
    read_d  = read_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_start && local_init_done) begin
          state_d = ST_ISSUE;
          read_d  = 1'b1;
          busy_d  = 1'b1;
          issue_d = '0;
          addr_d  = BASE;
        end
      end
      ST_ISSUE: begin
        if (accept) begin
          addr_d  = addr_q + ADDR_W'(1);
          issue_d = issue_q + ADDR_W'(1);
          if (issue_q == LAST_ISSUE) begin
            state_d = ST_DRAIN;
            read_d  = 1'b0;
          end else begin
            read_d = has_credit;
          end
        end else if (!read_q) begin
          read_d = has_credit;
        end
      end
      ST_DRAIN: begin
        if ((out_q == '0) && fifo_empty) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          addr_d  = BASE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Raster position of the FIFO head pixel.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (pop) begin
      if (x_q == X_W'(H_ACTIVE - 1)) begin
        x_d = '0;
        y_d = (y_q == Y_W'(V_ACTIVE - 1)) ? '0 : y_q + Y_W'(1);
      end else begin
        x_d = x_q + X_W'(1);
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= ST_IDLE;
      addr_q  <= BASE;
      issue_q <= '0;
      read_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      out_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      issue_q <= issue_d;
      read_q  <= read_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      out_q   <= out_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign head_px        = rgb_t'(fifo_rdata);
  assign avl_address    = addr_q;
  assign avl_read       = read_q;
  assign avl_burstbegin = read_q;
  assign pix_valid      = ~fifo_empty;
  assign pix_data       = fifo_empty ? '0 : {head_px.r, head_px.g, head_px.b};
  assign pix_sof        = pix_valid & (x_q == '0) & (y_q == '0);
  assign pix_eol        = pix_valid & (x_q == X_W'(H_ACTIVE - 1));
  assign busy           = busy_q;
  assign frame_done     = done_q;
  assign err_unexpected = err_q;

endmodule

// File: tb/tb_avalon_frame_reader.sv
// Scoreboard bench for avalon_frame_reader: random Avalon slave, reference pixel stream.
module tb_avalon_frame_reader;

  localparam int unsigned ADDR_W = 27;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned H      = 4;
  localparam int unsigned V      = 2;
  localparam int unsigned BASE   = 32'h100;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned FRAME  = H * V;

  logic              iCLK = 1'b0;
  logic              iRST = 1'b1;
  logic              local_init_done = 1'b0;
  logic              frame_start = 1'b0;
  logic              avl_waitrequest_n = 1'b1;
  logic [ADDR_W-1:0] avl_address;
  logic              avl_read, avl_burstbegin;
  logic [DATA_W-1:0] avl_readdata = '0;
  logic              avl_readdatavalid = 1'b0;
  logic [23:0]       pix_data;
  logic              pix_valid, pix_sof, pix_eol;
  logic              pix_ready = 1'b0;
  logic              busy, frame_done, err_unexpected;

  always #5 iCLK = ~iCLK;

  avalon_frame_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .H_ACTIVE(H), .V_ACTIVE(V),
    .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .local_init_done(local_init_done), .frame_start(frame_start),
    .avl_waitrequest_n(avl_waitrequest_n), .avl_address(avl_address), .avl_read(avl_read),
    .avl_burstbegin(avl_burstbegin), .avl_readdata(avl_readdata),
    .avl_readdatavalid(avl_readdatavalid), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_sof(pix_sof), .pix_eol(pix_eol), .busy(busy),
    .frame_done(frame_done), .err_unexpected(err_unexpected)
  );

  typedef struct packed {
    logic [23:0] d;
    logic        sof;
    logic        eol;
  } pix_t;

  typedef struct {
    int unsigned t;
    logic [31:0] d;
  } rsp_t;

  pix_t exp_q[$];
  rsp_t rq[$];

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          wr_mode = 0, ready_mode = 1, lat_mode = 0, stale_n = 0;
  bit          data_is_addr = 1'b1;
  int          mout = 0, mbuf = 0, n_acc = 0, n_pop = 0;
  bit          merr = 1'b0;
  int          frames_exp = 0, n_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input int unsigned a);
    if (data_is_addr) return a;
    return (a * 32'h9E3779B1) ^ 32'hC3A55A3C;
  endfunction

  // Reference stream: every frame is FRAME words from BASE, sof on pixel 0, eol at line ends.
  task automatic push_frame_expect();
    logic [31:0] w;
    pix_t e;
    for (int i = 0; i < int'(FRAME); i++) begin
      w     = mem_word(BASE + i);
      e.d   = w[23:0];
      e.sof = (i == 0);
      e.eol = ((i % H) == (H - 1));
      exp_q.push_back(e);
    end
  endtask

  // Driver: slave handshake, in-order returns, sink readiness.
  initial begin
    bit tog = 1'b0;
    forever begin
      @(posedge iCLK);
      cyc++;
      #1;
      tog = ~tog;
      case (wr_mode)
        0:       avl_waitrequest_n = 1'b1;
        1:       avl_waitrequest_n = tog;
        default: avl_waitrequest_n = ($urandom_range(0, 2) != 0);
      endcase
      case (ready_mode)
        0:       pix_ready = 1'b0;
        1:       pix_ready = 1'b1;
        default: pix_ready = ($urandom_range(0, 3) != 0);
      endcase
      avl_readdatavalid = 1'b0;
      avl_readdata      = $urandom;
      if (stale_n > 0) begin
        avl_readdatavalid = 1'b1;
        stale_n--;
      end else if (rq.size() > 0 && rq[0].t <= cyc) begin
        avl_readdatavalid = 1'b1;
        avl_readdata      = rq[0].d;
        void'(rq.pop_front());
      end
    end
  end

  // Slave-side scoreboard: addresses, stall stability, credit, buffering and error flag.
  initial begin
    bit              held = 1'b0;
    logic [ADDR_W-1:0] held_addr = '0;
    bit              acc, push, pop;
    int unsigned     lat;
    forever begin
      @(negedge iCLK);
      if (iRST) begin
        mout = 0; mbuf = 0; merr = 1'b0; n_acc = 0; held = 1'b0;
        rq.delete();
      end else begin
        check("pix_valid_vs_buffered", pix_valid, mbuf != 0);
        check("err_unexpected", err_unexpected, merr);
        check("burstbegin", avl_burstbegin, avl_read);
        if (held) begin
          check("stall_read_held", avl_read, 1);
          check("stall_addr_held", avl_address, held_addr);
        end
        held      = avl_read && !avl_waitrequest_n;
        held_addr = avl_address;
        acc       = avl_read && avl_waitrequest_n;
        if (acc) begin
          check("read_address", avl_address, 64'(BASE + (n_acc % FRAME)));
          n_acc++;
          lat = (lat_mode != 0) ? $urandom_range(1, 10) : 2;
          rq.push_back('{cyc + lat, mem_word(avl_address)});
        end
        push = avl_readdatavalid && (mout != 0);
        if (avl_readdatavalid && mout == 0) merr = 1'b1;
        pop  = pix_valid && pix_ready;
        mout = mout + int'(acc) - int'(push);
        mbuf = mbuf + int'(push) - int'(pop);
        if (acc) check("credit_bound", (mout + mbuf) <= int'(DEPTH), 1);
      end
    end
  end

  // Pixel monitor: pops expected pixels on every accepted transfer.
  initial begin
    bit   pend = 1'b0;
    pix_t prev = '0, got, e;
    forever begin
      @(negedge iCLK);
      if (iRST) begin
        pend = 1'b0;
      end else begin
        got = {pix_data, pix_sof, pix_eol};
        if (pend) check("hold_while_stalled", {pix_valid, got}, {1'b1, prev});
        if (pix_valid && pix_ready) begin
          check("pixel_was_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pixel", got, e);
          end
          n_pop++;
        end
        if (frame_done) n_done++;
        pend = pix_valid && !pix_ready;
        prev = got;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge iCLK);
    #2;
  endtask

  task automatic do_reset();
    @(posedge iCLK);
    #2 iRST = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge iCLK);
    #2 iRST = 1'b0;
  endtask

  task automatic start_frame(input bit expect_accept);
    @(posedge iCLK);
    #2 frame_start = 1'b1;
    if (expect_accept) push_frame_expect();
    @(posedge iCLK);
    #2 frame_start = 1'b0;
    @(negedge iCLK);
    check("busy_after_start", busy, expect_accept);
    check("read_rises_next_cycle", avl_read, expect_accept);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    do begin
      @(negedge iCLK);
      k++;
    end while (!frame_done && k < budget);
    if (!frame_done) begin
      checks++;
      errors++;
      $display("FAIL frame_done_timeout: no frame_done within %0d cycles", budget);
    end else begin
      frames_exp++;
      check("busy_low_at_done", busy, 0);
      check("addr_base_at_done", avl_address, BASE);
      check("exp_queue_drained", exp_q.size(), 0);
      @(negedge iCLK);
      check("done_single_cycle", frame_done, 0);
      check("read_idle_after_done", avl_read, 0);
    end
  endtask

  initial begin
    int a0, p0, d0, k;
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0, p0, k;
    // Reset state
    do_reset();
    @(negedge iCLK);
    check("rst_avl_read", avl_read, 0);
    check("rst_avl_address", avl_address, BASE);
    check("rst_busy", busy, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_data", pix_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err", err_unexpected, 0);

    // 1: basic frame, data = address
    local_init_done = 1'b1;
    start_frame(1);
    wait_done(500);
    tick(1);
    check("t1_reads_issued", n_acc, FRAME);

    // 2: sink stalled, credit limits reads to FIFO_DEPTH
    ready_mode = 0;
    a0 = n_acc;
    start_frame(1);
    tick(40);
    check("t2_reads_bounded", n_acc - a0, DEPTH);
    ready_mode = 1;
    wait_done(500);

    // 3: waitrequest toggling every cycle
    wr_mode = 1;
    start_frame(1);
    wait_done(500);
    wr_mode = 0;

    // 4: start without calibration, then a second start while busy
    local_init_done = 1'b0;
    a0 = n_acc;
    start_frame(0);
    tick(5);
    check("t4_no_reads_uncalibrated", n_acc - a0, 0);
    check("t4_idle_uncalibrated", busy, 0);
    local_init_done = 1'b1;
    p0 = n_pop;
    start_frame(1);
    tick(2);
    check("t4_busy_before_second_start", busy, 1);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    wait_done(500);
    tick(15);
    check("t4_one_frame_of_pixels", n_pop - p0, FRAME);
    check("t4_stays_idle", busy, 0);

    // 5: reset after 3 pixels, then stale returns
    data_is_addr = 1'b0;
    p0 = n_pop;
    start_frame(1);
    k = 0;
    while ((n_pop - p0) < 3 && k < 200) begin
      tick(1);
      k++;
    end
    check("t5_three_pixels_seen", (n_pop - p0) >= 3, 1);
    do_reset();
    stale_n = 2;
    tick(4);
    @(negedge iCLK);
    check("t5_err_sticky", err_unexpected, 1);
    check("t5_fifo_empty", pix_valid, 0);
    check("t5_busy_low", busy, 0);
    check("t5_read_low", avl_read, 0);
    check("t5_addr_base", avl_address, BASE);
    start_frame(1);
    wait_done(500);

    // 6: randomized waitrequest, latency 1..10 and sink readiness
    wr_mode = 2;
    lat_mode = 1;
    ready_mode = 2;
    for (int f = 0; f < 8; f++) begin
      start_frame(1);
      wait_done(2000);
      tick($urandom_range(0, 3));
    end
    tick(10);
    check("frame_done_pulses", n_done, frames_exp);
    check("no_leftover_expected", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_frame_reader.md
Name: avalon_frame_reader

Overview:
- Avalon-MM read master that fetches one video frame from the LPDDR2 frame buffer and presents it as a valid/ready pixel stream for the HDMI TX path.
- It is the read-side counterpart of the frame-buffer fill logic: same word-per-pixel layout, 0x00RRGGBB in bits [23:0], linear raster order.
- Issues pipelined single-word reads, bounded by the free space in an internal FIFO, so returned data is never dropped.

Parameters:
ADDR_W, 27, Avalon word address width
DATA_W, 32, Avalon data width (pixel in [23:0])
H_ACTIVE, 1920, pixels per line
V_ACTIVE, 1080, lines per frame
BASE_ADDR, 0, word address of pixel (0,0)
FIFO_DEPTH, 16, return-data FIFO entries (power of 2, >=4); also the max outstanding reads

Ports:
iCLK  in  1  sole clock (Avalon and pixel side)
iRST  in  1  synchronous, active-high reset
local_init_done  in  1  LPDDR2 calibration complete
frame_start  in  1  single-cycle request to read one frame
avl_waitrequest_n  in  1  Avalon ready; read accepted when avl_read && avl_waitrequest_n
avl_address  out  ADDR_W  read word address
avl_read  out  1  read request
avl_burstbegin  out  1  equals avl_read (burst length 1)
avl_readdata  in  DATA_W  returned data
avl_readdatavalid  in  1  returned data valid, in issue order
pix_data  out  24  RGB pixel
pix_valid  out  1  pixel available
pix_ready  in  1  sink accepts pixel when pix_valid && pix_ready
pix_sof  out  1  qualifies the first pixel of the frame
pix_eol  out  1  qualifies the last pixel of each line
busy  out  1  high from frame_start acceptance until frame_done
frame_done  out  1  one-cycle pulse after the last pixel is accepted
err_unexpected  out  1  sticky: readdatavalid seen with zero reads outstanding

Behaviour:
- Reset: every output is 0 and avl_address = BASE_ADDR. FIFO is emptied, counters cleared, err_unexpected cleared, FSM in IDLE.
- FSM states:
  - IDLE: frame_start && local_init_done -> ISSUE, busy=1. Otherwise frame_start is ignored.
  - ISSUE: avl_read=1 while credit is available. Credit = outstanding + fifo_count < FIFO_DEPTH.
    - On acceptance, outstanding++ and address++.
    - Acceptance at address BASE_ADDR+H_ACTIVE*V_ACTIVE-1 -> DRAIN, with avl_read=0 the next cycle.
    - When credit is exhausted, avl_read deasserts only after the current request has been accepted.
  - DRAIN: wait until outstanding==0, FIFO empty and the last pixel has been accepted -> DONE.
  - DONE: frame_done=1 for one cycle, busy=0, avl_address=BASE_ADDR -> IDLE.
- Avalon rules: while avl_read=1 and avl_waitrequest_n=0, avl_address and avl_read are held stable.
- Latency:
  - avl_read rises the cycle after frame_start is accepted.
  - A readdatavalid at cycle t gives pix_valid by t+1 when the FIFO was empty.
- Simultaneous accept and return in the same cycle: outstanding stays unchanged; the FIFO count changes independently on push and pop.
- Readdatavalid with outstanding==0 (e.g. stale data after a mid-frame reset):
  - data is discarded and err_unexpected is set;
  - no FIFO push.
- Pixel counters x and y advance on each accepted pixel:
  - x wraps at H_ACTIVE-1; y increments on x wrap.
  - pix_sof = pix_valid && x==0 && y==0.
  - pix_eol = pix_valid && x==H_ACTIVE-1.
- pix_data and the flags are held stable while pix_valid && !pix_ready.
- Width rules: the issue counter is ADDR_W bits. outstanding and fifo_count are clog2(FIFO_DEPTH)+1 bits, so neither overflows by construction.
- frame_start while busy is ignored and not queued.
- Reset mid-frame aborts immediately; nothing is resumed.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, ISSUE, DRAIN, DONE);
  - FRAME_PIXELS = H_ACTIVE*V_ACTIVE;
  - the pixel bit-field positions (R [23:16], G [15:8], B [7:0]), shared with the fill/write side.
- One sub-module: frame_reader_fifo.
  - Synchronous show-ahead FIFO with count output.
  - Push/pop in the same cycle is legal when full or empty-with-push.

Test Plan:
1. H=4,V=2, BASE=0x100, waitrequest_n=1, data=address, 2-cycle return latency, pix_ready=1 -> reads issued to 0x100..0x107. pix_data follows 0x100..0x107. sof on pixel 0, eol on pixels 3 and 7. frame_done once, busy returns to 0.
2. Same setup, pix_ready=0 for 40 cycles -> at most FIFO_DEPTH reads outstanding plus buffered, no data lost. After release the stream resumes in order without gaps in value.
3. waitrequest_n toggling 0/1 every cycle -> avl_address stable during every stall cycle, each address issued exactly once.
4. frame_start with local_init_done=0, then frame_start while busy -> no avl_read in the first case, the second request is ignored, exactly one frame output.
5. iRST pulsed after 3 pixels, then 2 stale readdatavalid -> outputs return to 0, err_unexpected=1, FIFO empty. A new frame_start reads from BASE again.
6. Full default 1920x1080 with random waitrequest_n and return latency 1-10 -> 2073600 pixels, 1080 eol, 1 sof, last read address BASE+0x1FA3FF.
